wb_interconnect_init_port: RTL
==============================

WB_INTERCONNECT_INIT_PORT -- requirements
Module: wb_interconnect_init_port

Interface
REQ-001 Parameter ADDR_WIDTH SHALL be 32, address width.
REQ-002 Parameter DATA_WIDTH SHALL be 32, data width; SEL width SHALL be DATA_WIDTH/8.
REQ-003 Parameter TGT_IDX_W SHALL be 1; N_TGT = 2**TGT_IDX_W targets.
REQ-004 Parameter TGT_SEL_LSB SHALL be 28; target index = adr[TGT_SEL_LSB +: TGT_IDX_W].
REQ-005 Parameter TIMEOUT_CYCLES SHALL be 256; used only per REQ-024.
REQ-006 Ports SHALL be, in order:
- clock, in, 1, sole clock, rising edge.
- reset, in, 1, synchronous active-high reset.
- i_adr/i_dat_w/i_sel, in, ADDR_WIDTH/DATA_WIDTH/SEL, initiator request fields.
- i_cyc/i_stb/i_we, in, 1 each, initiator cycle, strobe, write.
- i_dat_r, out, DATA_WIDTH, read data.
- i_ack/i_err, out, 1 each, initiator completion pulses.
- req, out, N_TGT, one-hot request to each per-target arbiter.
- gnt, in, N_TGT, this port's grant bit from each per-target arbiter.
- t_adr/t_dat_w/t_sel/t_we, out, registered forwarded request.
- t_cyc/t_stb, out, 1 each, target-side cycle/strobe.
- t_dat_r, in, N_TGT*DATA_WIDTH, per-target read data, target k at [k*DATA_WIDTH +: DATA_WIDTH].
- t_ack/t_err, in, N_TGT each, per-target completion.

Function
REQ-007 The block SHALL be an FSM with states IDLE, REQ, XFER, RESP.
REQ-008 IDLE: on i_cyc&i_stb, latch i_adr/i_dat_w/i_sel/i_we and target index tidx, go to REQ.
REQ-009 REQ: req SHALL be one-hot at bit tidx; all other req bits 0.
REQ-010 REQ: when gnt[tidx]=1, go to XFER; gnt bits other than tidx SHALL be ignored.
REQ-011 XFER: t_cyc=t_stb=1, t_* fields from latched values; req[tidx] held at 1.
REQ-012 XFER: on t_ack[tidx] or t_err[tidx], capture t_dat_r slice tidx and err flag, deassert t_cyc/t_stb and req next cycle, go to RESP.
REQ-013 If t_ack[tidx] and t_err[tidx] are both 1, err SHALL win.
REQ-014 RESP: exactly one cycle of i_ack (or i_err), i_dat_r = captured data; then IDLE.
REQ-015 i_dat_r SHALL hold its last captured value outside RESP.
REQ-016 Minimum latency: i_stb at cycle 0 -> req cycle 1 -> XFER cycle 2 (combinational gnt) -> i_ack cycle 3 (combinational t_ack).
REQ-017 A new request SHALL not be accepted until the cycle after RESP; back-to-back throughput is 1 per 4 cycles.
REQ-018 i_cyc=0 in REQ: drop req next cycle, go to IDLE, no i_ack/i_err.
REQ-019 i_cyc=0 in XFER: complete target cycle, then IDLE without i_ack/i_err.
REQ-020 Changes on i_adr/i_dat_w/i_sel/i_we after IDLE SHALL not affect the transfer in flight.
REQ-021 t_ack/t_err bits other than tidx SHALL be ignored in all states.

Reset
REQ-022 reset SHALL force IDLE and drive req=0, t_cyc=0, t_stb=0, i_ack=0, i_err=0, i_dat_r=0, t_adr=0, t_dat_w=0, t_sel=0, t_we=0 in the following cycle.
REQ-023 reset asserted in any state SHALL abandon the transfer; no i_ack/i_err SHALL be produced for it.

Configuration
REQ-024 Macro WB_INTERCONNECT_INIT_PORT_TIMEOUT_EN defined: a counter cleared on entry to REQ SHALL count cycles in REQ and XFER; at TIMEOUT_CYCLES it forces RESP with i_err=1, i_dat_r unchanged, req/t_cyc/t_stb dropped. Undefined: no counter, the block waits indefinitely.

Verification
REQ-025 Read, adr=0x1000_0004, gnt[1] and t_ack[1] combinational, t_dat_r slice1=0xCAFEF00D -> req=2'b10 cycle 1, i_ack cycle 3, i_dat_r=0xCAFEF00D.
REQ-026 Write, adr=0x0000_0010, dat=0x12345678, sel=4'hF, gnt[0] delayed 5 cycles -> t_stb only after gnt, t_dat_w=0x12345678, single i_ack.
REQ-027 t_err[0]&t_ack[0] same cycle -> i_err=1, i_ack=0.
REQ-028 i_cyc dropped in REQ before gnt -> req cleared next cycle, no i_ack; i_cyc dropped in XFER -> target cycle completes, no i_ack.
REQ-029 Timeout macro defined, TIMEOUT_CYCLES=8, gnt never asserted -> i_err pulse after 8 REQ cycles, req=0 after; macro undefined -> no i_err after 1000 cycles.
REQ-030 reset pulsed in XFER -> all outputs 0 next cycle, no i_ack; next request proceeds normally.

Source files
------------

// File: rtl/wb_interconnect_init_port.sv
// Wishbone initiator-side port of a shared-bus interconnect: routes one request at a time to a target arbiter.
// Optional request/transfer watchdog enabled by defining WB_INTERCONNECT_INIT_PORT_TIMEOUT_EN.
module wb_interconnect_init_port #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TGT_IDX_W      = 1,
  parameter int TGT_SEL_LSB    = 28,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int SEL_WIDTH     = DATA_WIDTH / 8,
  localparam int N_TGT         = 2 ** TGT_IDX_W
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [ADDR_WIDTH-1:0]       i_adr,
  input  logic [DATA_WIDTH-1:0]       i_dat_w,
  input  logic [SEL_WIDTH-1:0]        i_sel,
  input  logic                        i_cyc,
  input  logic                        i_stb,
  input  logic                        i_we,
  output logic [DATA_WIDTH-1:0]       i_dat_r,
  output logic                        i_ack,
  output logic                        i_err,
  output logic [N_TGT-1:0]            req,
  input  logic [N_TGT-1:0]            gnt,
  output logic [ADDR_WIDTH-1:0]       t_adr,
  output logic [DATA_WIDTH-1:0]       t_dat_w,
  output logic [SEL_WIDTH-1:0]        t_sel,
  output logic                        t_we,
  output logic                        t_cyc,
  output logic                        t_stb,
  input  logic [N_TGT*DATA_WIDTH-1:0] t_dat_r,
  input  logic [N_TGT-1:0]            t_ack,
  input  logic [N_TGT-1:0]            t_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_XFER = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  logic [1:0]           state;
  logic [TGT_IDX_W-1:0] tidx;
  logic                 err_q;
  logic                 abort_q;
  logic                 done;
  logic                 abandon;
  logic                 to_hit;
  logic [DATA_WIDTH-1:0] sel_dat;

  // Only the addressed target's completion and data matter; other bits are ignored.
  assign done    = t_ack[tidx] | t_err[tidx];
  assign abandon = abort_q | ~i_cyc;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    sel_dat = '0;
    for (int k = 0; k < N_TGT; k++) begin
      if (tidx == TGT_IDX_W'(k)) sel_dat = t_dat_r[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    req = '0;
    if (state == ST_REQ || state == ST_XFER) req[tidx] = 1'b1;
  end

  assign t_cyc = (state == ST_XFER);
  assign t_stb = (state == ST_XFER);
  assign i_ack = (state == ST_RESP) & ~err_q;
  assign i_err = (state == ST_RESP) & err_q;

`ifdef WB_INTERCONNECT_INIT_PORT_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt;

  // Cleared while idle, so it starts at zero on entry to REQ.
  always_ff @(posedge clock) begin
    if (reset || state == ST_IDLE) cnt <= '0;
    else if (state == ST_REQ || state == ST_XFER) cnt <= cnt + 1'b1;
  end

  assign to_hit = (state == ST_REQ || state == ST_XFER) && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign to_hit = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_IDLE;
      tidx    <= '0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
      i_dat_r <= '0;
      t_adr   <= '0;
      t_dat_w <= '0;
      t_sel   <= '0;
      t_we    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_cyc && i_stb) begin
            t_adr   <= i_adr;
            t_dat_w <= i_dat_w;
            t_sel   <= i_sel;
            t_we    <= i_we;
            tidx    <= i_adr[TGT_SEL_LSB +: TGT_IDX_W];
            abort_q <= 1'b0;
            state   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (!i_cyc) begin
            state <= ST_IDLE;
          end else if (gnt[tidx]) begin
            state <= ST_XFER;
          end else if (to_hit) begin
            err_q <= 1'b1;
            state <= ST_RESP;
          end
        end
        ST_XFER: begin
          if (done) begin
            // An initiator that dropped its cycle still lets the target finish, but gets no response.
            if (abandon) begin
              state <= ST_IDLE;
            end else begin
              i_dat_r <= sel_dat;
              err_q   <= t_err[tidx];
              state   <= ST_RESP;
            end
          end else if (to_hit) begin
            err_q <= 1'b1;
            state <= abandon ? ST_IDLE : ST_RESP;
          end else if (!i_cyc) begin
            abort_q <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
